// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: FF46 write copies OAM_LEN bytes from a 256-byte source
// page into OAM. ROM pages are fetched over the cart ROM address mux, all
// other pages over the ext port. CPU ROM reads during a ROM-sourced
// transfer see 8'hFF (DMG bus conflict).
module oam_dma_ctrl #(
  parameter int ROM_AW  = 15,
  parameter int OAM_LEN = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mce,
  input  logic              reg_we,
  input  logic [7:0]        reg_wdata,
  output logic [7:0]        reg_rdata,
  input  logic [ROM_AW-1:0] cpu_rom_addr,
  output logic [7:0]        cpu_rom_data,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [15:0]       ext_addr,
  output logic              ext_rd,
  input  logic [7:0]        ext_data,
  output logic              oam_we,
  output logic [7:0]        oam_addr,
  output logic [7:0]        oam_wdata,
  output logic              dma_active
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER} state_t;

  state_t     r_state;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_cap_idx;
  logic       r_cap_pend;
  logic       r_cap_src;   // 1: capture from rom_data, 0: from ext_data
  logic       r_own_q;

  logic       w_rom_pg;
  logic       w_fetch;
  logic       w_own;

  // Pages below 2^(ROM_AW-8) live in cart ROM.
  assign w_rom_pg = ({1'b0, r_page} < 9'(1 << (ROM_AW - 8)));
  // A restart on the same mce suppresses the fetch.
  assign w_fetch  = (r_state == S_XFER) && mce && !reg_we;
  // DMA holds the ROM bus for every clk of a ROM-sourced XFER, not just mce.
  assign w_own    = (r_state == S_XFER) && w_rom_pg;

  assign rom_addr     = w_own ? {r_page[ROM_AW-9:0], r_idx} : cpu_rom_addr;
  assign ext_rd       = w_fetch && !w_rom_pg;
  assign ext_addr     = ext_rd ? {r_page, r_idx} : 16'h0000;
  // own_q lines up with the prom's one-clk read latency.
  assign cpu_rom_data = r_own_q ? 8'hFF : rom_data;
  assign reg_rdata    = r_page;
  assign dma_active   = (r_state != S_IDLE);

  // Sequencer, fetch/capture pipeline and registered OAM write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_page     <= 8'hFF;
      r_idx      <= 8'd0;
      r_cap_idx  <= 8'd0;
      r_cap_pend <= 1'b0;
      r_cap_src  <= 1'b0;
      r_own_q    <= 1'b0;
      oam_we     <= 1'b0;
      oam_addr   <= 8'd0;
      oam_wdata  <= 8'd0;
    end else begin
      r_own_q    <= w_own;
      r_cap_pend <= w_fetch;
      if (w_fetch) begin
        r_cap_src <= w_rom_pg;
        r_cap_idx <= r_idx;
      end
      // Capture is independent of state so a pending byte survives a restart.
      oam_we <= r_cap_pend;
      if (r_cap_pend) begin
        oam_addr  <= r_cap_idx;
        oam_wdata <= r_cap_src ? rom_data : ext_data;
      end
      if (reg_we) begin
        r_page  <= reg_wdata;
        r_idx   <= 8'd0;
        r_state <= S_SETUP;
      end else begin
        case (r_state)
          S_SETUP: if (mce) r_state <= S_XFER;
          S_XFER: if (mce) begin
            r_idx <= r_idx + 8'd1;
            if (r_idx == 8'(OAM_LEN - 1)) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl against an M-cycle-level transfer model.
module tb_oam_dma_ctrl;
  localparam int ROM_AW = 15;
  localparam int LEN    = 160;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mce = 1'b0;
  logic              reg_we = 1'b0;
  logic [7:0]        reg_wdata = 8'h00;
  logic [7:0]        reg_rdata;
  logic [ROM_AW-1:0] cpu_rom_addr = '0;
  logic [7:0]        cpu_rom_data;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data = 8'h00;
  logic [15:0]       ext_addr;
  logic              ext_rd;
  logic [7:0]        ext_data = 8'h00;
  logic              oam_we;
  logic [7:0]        oam_addr;
  logic [7:0]        oam_wdata;
  logic              dma_active;

  oam_dma_ctrl #(.ROM_AW(ROM_AW), .OAM_LEN(LEN)) dut (
    .clk(clk), .rst(rst), .mce(mce), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .cpu_rom_addr(cpu_rom_addr), .cpu_rom_data(cpu_rom_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .ext_addr(ext_addr), .ext_rd(ext_rd),
    .ext_data(ext_data), .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  // Memories: registered cart prom and ext side.
  logic [7:0] rom_mem [0:32767];
  logic [7:0] ext_mem [0:65535];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];
  always @(posedge clk) if (ext_rd) ext_data <= ext_mem[ext_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // mce / CPU address driver
  int   mce_per = 4;
  int   mce_cnt = 0;
  logic fix150  = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      mce_cnt++;
      if (mce_cnt >= mce_per) begin mce_cnt = 0; mce = 1'b1; end
      else mce = 1'b0;
      cpu_rom_addr = fix150 ? 15'h0150 : 15'($urandom);
    end
  end

  // Transfer model: one step per M-cycle, expected OAM writes in a queue.
  typedef struct { int idx; logic [7:0] data; } wr_t;
  wr_t        expq[$];
  logic       m_act = 1'b0, m_setup = 1'b0;
  logic [7:0] m_page = 8'hFF;
  int         m_idx = 0;
  logic       own_prev = 1'b0, cr_ok = 1'b0;
  logic [ROM_AW-1:0] addr_prev = '0;

  function automatic logic is_rom(input logic [7:0] p);
    return int'(p) < (1 << (ROM_AW - 8));
  endfunction

  function automatic logic [7:0] src_byte(input logic [7:0] p, input int i);
    if (is_rom(p)) return rom_mem[int'(p) * 256 + i];
    return ext_mem[int'(p) * 256 + i];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0; m_setup = 1'b0; m_page = 8'hFF; m_idx = 0;
      own_prev = 1'b0; cr_ok = 1'b0;
      expq.delete();
    end else begin
      own_prev  = m_act && !m_setup && is_rom(m_page);
      addr_prev = cpu_rom_addr;
      cr_ok     = 1'b1;
      if (reg_we) begin
        m_act = 1'b1; m_setup = 1'b1; m_page = reg_wdata; m_idx = 0;
      end else if (mce && m_act) begin
        if (m_setup) m_setup = 1'b0;
        else begin
          expq.push_back('{m_idx, src_byte(m_page, m_idx)});
          m_idx++;
          if (m_idx == LEN) m_act = 1'b0;
        end
      end
    end
  end

  // Per-cycle checks on the falling edge.
  int n_oam = 0, n_ext = 0, n_mce_act = 0;
  always @(negedge clk) begin
    if (!rst) begin
      logic xfer;
      wr_t  e;
      xfer = m_act && !m_setup;
      chk("dma_active", 32'(dma_active), 32'(m_act));
      chk("rom_addr", 32'(rom_addr),
          (xfer && is_rom(m_page)) ? 32'(int'(m_page[6:0]) * 256 + m_idx) : 32'(cpu_rom_addr));
      chk("ext_rd", 32'(ext_rd), 32'(xfer && !is_rom(m_page) && mce && !reg_we));
      if (ext_rd) begin
        n_ext++;
        chk("ext_addr", 32'(ext_addr), 32'(int'(m_page) * 256 + m_idx));
      end
      if (cr_ok) chk("cpu_rom_data", 32'(cpu_rom_data), own_prev ? 32'hFF : 32'(rom_mem[addr_prev]));
      chk("reg_rdata", 32'(reg_rdata), 32'(m_page));
      if (mce && dma_active) n_mce_act++;
      if (oam_we) begin
        n_oam++;
        if (expq.size() == 0) chk("oam_extra", 32'(oam_we), 32'd0);
        else begin
          e = expq.pop_front();
          chk("oam_addr", 32'(oam_addr), 32'(e.idx));
          chk("oam_wdata", 32'(oam_wdata), 32'(e.data));
        end
      end
    end
  end

  task automatic wr(input logic [7:0] p);
    @(posedge clk); #1;
    reg_we = 1'b1; reg_wdata = p;
    @(posedge clk); #1;
    reg_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((m_act || expq.size() != 0) && n < 4000) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    chk(tag, 32'(expq.size()) + 32'(m_act), 32'd0);
  endtask

  task automatic wait_idx(input int i);
    int n = 0;
    while (!(m_act && !m_setup && m_idx >= i) && n < 4000) begin @(posedge clk); n++; end
    chk("idx_timeout", 32'(n >= 4000), 32'd0);
  endtask

  initial begin
    int o0, e0, a0, nb;
    for (int i = 0; i < 32768; i++) rom_mem[i] = 8'($urandom);
    for (int i = 0; i < 65536; i++) ext_mem[i] = 8'($urandom);
    #23;
    // reset values
    chk("rst_dma_active", 32'(dma_active), 0);
    chk("rst_oam_we", 32'(oam_we), 0);
    chk("rst_ext_rd", 32'(ext_rd), 0);
    chk("rst_reg_rdata", 32'(reg_rdata), 32'hFF);
    chk("rst_oam_addr", 32'(oam_addr), 0);
    chk("rst_oam_wdata", 32'(oam_wdata), 0);
    chk("rst_ext_addr", 32'(ext_addr), 0);
    @(posedge clk); #3; rst = 1'b0;

    // ROM page 0x12 with a held CPU read of 0x0150
    mce_per = 4; fix150 = 1'b1;
    o0 = n_oam; a0 = n_mce_act;
    wr(8'h12);
    wait_idle("p12_done");
    chk("p12_count", 32'(n_oam - o0), LEN);
    chk("p12_mce_active", 32'(n_mce_act - a0), LEN + 1);
    chk("p12_rdata", 32'(reg_rdata), 32'h12);
    @(posedge clk); #2;
    chk("cpu150_after", 32'(cpu_rom_data), 32'(rom_mem[15'h0150]));
    fix150 = 1'b0;

    // ext page 0xC0
    o0 = n_oam; e0 = n_ext;
    wr(8'hC0);
    wait_idle("pc0_done");
    chk("pc0_count", 32'(n_oam - o0), LEN);
    chk("pc0_ext_rd", 32'(n_ext - e0), LEN);

    // restart at idx 50
    o0 = n_oam;
    wr(8'h12);
    wait_idx(50);
    #1; reg_we = 1'b1; reg_wdata = 8'h20;
    @(posedge clk); #1; reg_we = 1'b0;
    wait_idle("restart_done");
    chk("restart_count", 32'(n_oam - o0), 50 + LEN);

    // restart coincident with mce
    mce_per = 3; o0 = n_oam;
    wr(8'h05);
    wait_idx(20);
    begin
      int n = 0;
      do begin @(posedge clk); #2; n++; end while (!mce && n < 100);
    end
    nb = m_idx;
    reg_we = 1'b1; reg_wdata = 8'h9A;
    @(posedge clk); #1; reg_we = 1'b0;
    wait_idle("coinc_done");
    chk("coinc_count", 32'(n_oam - o0), 32'(nb + LEN));

    // random transfers, some restarted
    for (int t = 0; t < 5; t++) begin
      mce_per = $urandom_range(2, 6);
      wr(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        wait_idx($urandom_range(1, LEN - 1));
        #1; reg_we = 1'b1; reg_wdata = 8'($urandom);
        @(posedge clk); #1; reg_we = 1'b0;
      end
      wait_idle("rand_done");
    end

    // reset mid-transfer at idx 40
    mce_per = 4;
    wr(8'h12);
    wait_idx(40);
    #3; rst = 1'b1; #1;
    chk("midrst_dma_active", 32'(dma_active), 0);
    chk("midrst_reg_rdata", 32'(reg_rdata), 32'hFF);
    chk("midrst_oam_we", 32'(oam_we), 0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'(cpu_rom_addr));
    repeat (3) @(posedge clk);
    #3; rst = 1'b0;
    o0 = n_oam;
    repeat (40) @(posedge clk);
    chk("midrst_no_oam", 32'(n_oam - o0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
